fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register feeding the decode/control stage.
- Holds the PC, drives the instruction-memory address and latches the fetched word plus PC context for decode.
- Applies redirects from branch/JAL/JALR resolution and load-use stalls.
- Halts permanently when decode flags an EBREAK via the control unit's active-low EB output.

---
 rtl/fetch_stage.sv | 70 +++++++
 tb/tb_fetch_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC + IF/ID register with redirect/stall/EBREAK halt; FETCH_PERF_CNT_EN adds fetch/bubble counters
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] redirect_target,
    input  logic        eb_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count,
`endif
    output logic        halted
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_nx;
    logic [31:0] pc, pc_nx, ifid_pc_nx, ifid_pc4_nx, ifid_inst_nx;
    logic ifid_valid_nx, redirect, halt_req, advance, bubble;
    always_comb begin
        redirect = state == RUN && pc_src;
        halt_req = state == RUN && !pc_src && !eb_n && ifid_valid;
        advance = state == RUN && !pc_src && !halt_req && !stall;
        bubble = redirect || halt_req;
        state_nx = halt_req ? HALT : state;
        pc_nx = redirect ? {redirect_target[31:1], 1'b0} : advance ? pc + 32'd4 : pc;
        ifid_pc_nx = advance ? pc : ifid_pc;
        ifid_pc4_nx = advance ? pc + 32'd4 : ifid_pc4;
        ifid_inst_nx = bubble ? NOP_INST : advance ? imem_rdata : ifid_inst;
        ifid_valid_nx = bubble ? 1'b0 : advance ? 1'b1 : ifid_valid;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc <= RESET_PC;
            ifid_pc <= '0;
            ifid_pc4 <= '0;
            ifid_inst <= NOP_INST;
            ifid_valid <= 1'b0;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
            ifid_pc <= ifid_pc_nx;
            ifid_pc4 <= ifid_pc4_nx;
            ifid_inst <= ifid_inst_nx;
            ifid_valid <= ifid_valid_nx;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            bubble_count <= '0;
        end else begin
            fetch_count <= fetch_count + {31'd0, advance};
            bubble_count <= bubble_count + {31'd0, bubble};
        end
    end
`endif
    assign imem_addr = pc;
    assign halted = state == HALT;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a behavioural model
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0033;
    logic clk = 0, rst = 1, stall = 0, pc_src = 0, eb_n = 1;
    logic [31:0] redirect_target = 0;
    logic [31:0] imem_addr, imem_rdata, ifid_pc, ifid_pc4, ifid_inst;
    logic ifid_valid, halted;
    logic [31:0] a2, r2, p2, p42, i2;
    logic v2, h2;
    logic [31:0] fc, bc, fc2, bc2;
    logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_fc, m_bc;
    logic m_valid, m_halt;
    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem(imem_addr);
    assign r2 = mem(a2);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .redirect_target(redirect_target),
        .eb_n(eb_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ifid_pc(ifid_pc),
        .ifid_pc4(ifid_pc4), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fc), .bubble_count(bc),
`endif
        .halted(halted)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .stall(1'b0), .pc_src(1'b0), .redirect_target(32'h0),
        .eb_n(1'b1), .imem_addr(a2), .imem_rdata(r2), .ifid_pc(p2),
        .ifid_pc4(p42), .ifid_inst(i2), .ifid_valid(v2),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fc2), .bubble_count(bc2),
`endif
        .halted(h2)
    );

    // Model the clock edge from the current inputs, then let the DUT take the same edge.
    task automatic cyc;
        if (rst) begin
            m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_inst = NOP; m_valid = 0; m_halt = 0; m_fc = 0; m_bc = 0;
        end else if (!m_halt) begin
            if (pc_src) begin
                m_pc = redirect_target & ~32'd1; m_inst = NOP; m_valid = 0; m_bc++;
            end else if (!eb_n && m_valid) begin
                m_halt = 1; m_inst = NOP; m_valid = 0; m_bc++;
            end else if (!stall) begin
                m_ipc = m_pc; m_ipc4 = m_pc + 4; m_inst = mem(m_pc); m_valid = 1; m_pc += 4; m_fc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; cyc(); rst = 0;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_pc got %h want %h", imem_addr, 32'h0); else n_pass++;
        n_total++; if ({ifid_pc, ifid_pc4, ifid_inst, ifid_valid, halted} !== {32'h0, 32'h0, NOP, 1'b0, 1'b0})
            $display("FAIL reset_ifid got %h/%h/%h/%b/%b want 0/0/%h/0/0", ifid_pc, ifid_pc4, ifid_inst, ifid_valid, halted, NOP);
        else n_pass++;
    endtask

    task automatic test_sequence;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            n_total++; if (imem_addr !== 32'(4 * k)) $display("FAIL seq_pc got %h want %h", imem_addr, 32'(4 * k)); else n_pass++;
            n_total++; if ({ifid_pc, ifid_pc4, ifid_inst, ifid_valid} !== {32'(4 * k - 4), 32'(4 * k), mem(32'(4 * k - 4)), 1'b1})
                $display("FAIL seq_ifid got %h/%h/%h/%b want %h", ifid_pc, ifid_pc4, ifid_inst, ifid_valid, 32'(4 * k - 4));
            else n_pass++;
        end
    endtask

    task automatic test_stall;
        rst = 1; cyc(); rst = 0; cyc(); cyc();
        stall = 1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_total++; if ({imem_addr, ifid_pc} !== {32'h8, 32'h4}) $display("FAIL stall_hold got pc %h ifid_pc %h want 8/4", imem_addr, ifid_pc); else n_pass++;
        end
        stall = 0; cyc();
        n_total++; if ({imem_addr, ifid_pc} !== {32'hC, 32'h8}) $display("FAIL stall_release got pc %h ifid_pc %h want c/8", imem_addr, ifid_pc); else n_pass++;
    endtask

    task automatic test_redirect;
        stall = 1; pc_src = 1; redirect_target = 32'h0000_0101; cyc();
        n_total++; if ({imem_addr, ifid_valid, ifid_inst} !== {32'h100, 1'b0, NOP})
            $display("FAIL redirect got pc %h valid %b inst %h want 100/0/%h", imem_addr, ifid_valid, ifid_inst, NOP);
        else n_pass++;
        stall = 0; pc_src = 0; cyc();
        n_total++; if ({ifid_pc, ifid_valid, imem_addr} !== {32'h100, 1'b1, 32'h104})
            $display("FAIL redirect_follow got ifid_pc %h valid %b pc %h want 100/1/104", ifid_pc, ifid_valid, imem_addr);
        else n_pass++;
    endtask

    task automatic test_halt;
        rst = 1; cyc(); rst = 0; cyc(); cyc();
        eb_n = 0; cyc();
        n_total++; if ({halted, imem_addr, ifid_valid, ifid_inst} !== {1'b1, 32'h8, 1'b0, NOP})
            $display("FAIL halt_enter got h %b pc %h valid %b inst %h want 1/8/0/%h", halted, imem_addr, ifid_valid, ifid_inst, NOP);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            pc_src = 1'($urandom); stall = 1'($urandom); eb_n = 1'($urandom); redirect_target = $urandom;
            cyc();
            n_total++; if ({halted, imem_addr, ifid_valid} !== {1'b1, 32'h8, 1'b0})
                $display("FAIL halt_frozen got h %b pc %h valid %b want 1/8/0", halted, imem_addr, ifid_valid);
            else n_pass++;
        end
        pc_src = 0; stall = 0; eb_n = 1; rst = 1; cyc(); rst = 0;
        n_total++; if ({halted, imem_addr} !== {1'b0, 32'h0}) $display("FAIL halt_reset got h %b pc %h want 0/0", halted, imem_addr); else n_pass++;
    endtask

    task automatic test_eb_redirect;
        cyc(); cyc();
        eb_n = 0; pc_src = 1; redirect_target = 32'h40; cyc();
        n_total++; if ({halted, imem_addr} !== {1'b0, 32'h40}) $display("FAIL eb_redirect got h %b pc %h want 0/40", halted, imem_addr); else n_pass++;
        pc_src = 0; cyc();
        n_total++; if ({halted, imem_addr, ifid_valid} !== {1'b0, 32'h44, 1'b1})
            $display("FAIL eb_bubble got h %b pc %h valid %b want 0/44/1", halted, imem_addr, ifid_valid);
        else n_pass++;
        eb_n = 1;
    endtask

    task automatic test_wrap;
        rst = 1; cyc(); rst = 0;
        n_total++; if (a2 !== 32'hFFFF_FFF8) $display("FAIL wrap_reset got %h want fffffff8", a2); else n_pass++;
        cyc();
        n_total++; if (a2 !== 32'hFFFF_FFFC) $display("FAIL wrap_pc1 got %h want fffffffc", a2); else n_pass++;
        cyc();
        n_total++; if ({a2, p2, p42} !== {32'h0, 32'hFFFF_FFFC, 32'h0}) $display("FAIL wrap_pc2 got %h/%h/%h want 0/fffffffc/0", a2, p2, p42); else n_pass++;
        cyc();
`ifdef FETCH_PERF_CNT_EN
        n_total++; if ({fc2, bc2} !== {32'd3, 32'd0}) $display("FAIL wrap_counts got %0d/%0d want 3/0", fc2, bc2); else n_pass++;
`endif
        n_total++; if (a2 !== 32'h4) $display("FAIL wrap_pc3 got %h want 4", a2); else n_pass++;
    endtask

    task automatic test_random;
        rst = 1; cyc(); rst = 0;
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) < 3);
            stall = ($urandom_range(0, 3) == 0);
            pc_src = ($urandom_range(0, 9) == 0);
            eb_n = ($urandom_range(0, 39) != 0);
            redirect_target = $urandom;
            cyc();
            n_total++; if ({imem_addr, ifid_pc, ifid_pc4, ifid_inst, ifid_valid, halted} !== {m_pc, m_ipc, m_ipc4, m_inst, m_valid, m_halt})
                $display("FAIL random[%0d] got %h/%h/%h/%h/%b/%b want %h/%h/%h/%h/%b/%b", k, imem_addr, ifid_pc, ifid_pc4, ifid_inst,
                         ifid_valid, halted, m_pc, m_ipc, m_ipc4, m_inst, m_valid, m_halt);
            else n_pass++;
`ifdef FETCH_PERF_CNT_EN
            n_total++; if ({fc, bc} !== {m_fc, m_bc}) $display("FAIL random_cnt[%0d] got %0d/%0d want %0d/%0d", k, fc, bc, m_fc, m_bc); else n_pass++;
`endif
        end
        rst = 0; stall = 0; pc_src = 0; eb_n = 1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_halt();
        test_eb_redirect();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
